// File: rtl/fft_unload_pkg.sv
// Shared definitions for the COREFFT result-memory unloader:
// default widths, the unload FSM states and an index bit-reversal helper.
package fft_unload_pkg;

    localparam int ADDR_W_DEFAULT = 11;
    localparam int DATA_W_DEFAULT = 64;
    localparam int BITREV_MAX_W   = 16;
    localparam int BITREV_IDX_W   = $clog2(BITREV_MAX_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } unload_state_t;

    // Reverses the low 'width' bits of value; upper bits come back as zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] value,
                                                       input int width);
        logic [BITREV_MAX_W-1:0] result;
        result = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            if (i < width) begin
                result[BITREV_IDX_W'(i)] = value[BITREV_IDX_W'(width - 1 - i)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_unload_fifo.sv
// Small register-based synchronous FIFO holding tagged RAM words;
// the head entry is read combinationally so it can drive the output stream directly.
module fft_unload_fifo #(
    parameter int WIDTH = 75,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign rdata = mem[rd_ptr];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign wr_ok = push && (!full || pop);
    assign rd_ok = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_unloader.sv
// Sweeps the COREFFT result RAM read port over one frame after 'start' and
// streams the samples out as valid/ready beats with index and first/last markers.
module fft_frame_unloader
    import fft_unload_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int RD_LAT     = 2,
    parameter int BITREV     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                NGRST,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   RADDR,
    output logic                DO_en,
    output logic                DO_rst,
    input  logic [DATA_W-1:0]   RDATA,
    output logic [DATA_W/2-1:0] out_re,
    output logic [DATA_W/2-1:0] out_im,
    output logic [ADDR_W-1:0]   out_idx,
    output logic                out_first,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int HALF_W = DATA_W / 2;
    localparam int FIFO_W = DATA_W + ADDR_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    unload_state_t     state;
    unload_state_t     state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] raddr_next;
    logic [ADDR_W-1:0] idx_issued;
    logic [RD_LAT-1:0] vld_pipe;
    logic [ADDR_W-1:0] idx_pipe [RD_LAT];
    logic [FIFO_W-1:0] head;
    logic [ADDR_W-1:0] head_idx;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              pop;
    logic              issue;
    logic              finish;
    logic              credit_ok;
    int                outstanding;

    assign raddr_next = (BITREV != 0) ? ADDR_W'(bitrev(BITREV_MAX_W'(cnt), ADDR_W)) : cnt;

    assign busy      = (state != IDLE);
    assign head_idx  = head[ADDR_W-1:0];
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_re    = head[FIFO_W-1 -: HALF_W];
    assign out_im    = head[ADDR_W +: HALF_W];
    assign out_idx   = head_idx;
    assign out_first = out_valid && (head_idx == '0);
    assign out_last  = out_valid && (head_idx == LAST_IDX);

    // Every word already requested from the RAM or still queued owns a FIFO slot,
    // so a new read is issued only when a free slot is guaranteed on its arrival.
    always_comb begin
        outstanding = int'(rd_en) + int'(fifo_count) - int'(pop);
        for (int i = 0; i < RD_LAT; i++) begin
            outstanding = outstanding + int'(vld_pipe[i]);
        end
        credit_ok = (outstanding <= FIFO_DEPTH - 1);
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issue = credit_ok;
                if (issue && (cnt == LAST_IDX)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (head_idx == LAST_IDX)) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // rd_en/RADDR are registered, so the latency pipe starts one cycle after the issue decision.
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            cnt        <= '0;
            rd_en      <= 1'b0;
            RADDR      <= '0;
            idx_issued <= '0;
            done       <= 1'b0;
            DO_en      <= 1'b0;
            DO_rst     <= 1'b0;
            vld_pipe   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                idx_pipe[i] <= '0;
            end
        end else begin
            DO_en  <= 1'b1;
            DO_rst <= (state == IDLE) && start;
            done   <= finish;
            rd_en  <= issue;
            if ((state == IDLE) && start) begin
                cnt <= '0;
            end else if (issue) begin
                cnt <= cnt + 1'b1;
            end
            if (issue) begin
                RADDR      <= raddr_next;
                idx_issued <= cnt;
            end
            vld_pipe[0] <= rd_en;
            idx_pipe[0] <= idx_issued;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    fft_unload_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (NGRST),
        .push  (vld_pipe[RD_LAT-1]),
        .wdata ({RDATA, idx_pipe[RD_LAT-1]}),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule
